// File: rtl/cpumc_banked_pkg.sv
// cpumc_banked_pkg: shared mode, flash request, FSM state and address region definitions
package cpumc_banked_pkg;

    typedef enum logic [1:0] {
        MODE_NROM128 = 2'd0,
        MODE_NROM256 = 2'd1,
        MODE_UXROM   = 2'd2,
        MODE_PROG    = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        RT_RD = 2'd0,
        RT_WR = 2'd1,
        RT_ER = 2'd2
    } req_type_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEM_RD,
        ST_FL_ISSUE,
        ST_FL_WAIT
    } state_t;

    typedef enum logic [2:0] {
        RG_RAM,
        RG_NONE,
        RG_BPORT,
        RG_SRAM,
        RG_PRG
    } region_t;

    localparam logic [15:0] RAM_END    = 16'h2000;
    localparam logic [15:0] BPORT_BASE = 16'h4020;
    localparam logic [15:0] SRAM_BASE  = 16'h6000;
    localparam logic [15:0] PRG_BASE   = 16'h8000;

    function automatic region_t region_of(input logic [15:0] a);
        return a >= PRG_BASE   ? RG_PRG   :
               a >= SRAM_BASE  ? RG_SRAM  :
               a >= BPORT_BASE ? RG_BPORT :
               a >= RAM_END    ? RG_NONE  : RG_RAM;
    endfunction

endpackage

// File: rtl/cpumc_prg_map.sv
// cpumc_prg_map: maps mapper mode, bank register and CPU PRG offset to a 24-bit flash address
module cpumc_prg_map
    import cpumc_banked_pkg::*;
#(
    parameter int BANK_W = 4
) (
    input  mode_t             mode,
    input  logic [BANK_W-1:0] bank,
    input  logic [3:0]        last,
    input  logic [14:0]       addr,
    output logic [23:0]       fa
);

    logic [BANK_W-1:0] last_b;

    assign last_b = BANK_W'(last);

    // NROM windows are fixed; UxROM pins the upper window to the last bank
    always_comb begin
        fa = mode == MODE_NROM128 ? 24'(addr[13:0]) :
             mode == MODE_NROM256 ? 24'(addr) :
             24'({(mode == MODE_UXROM && addr[14]) ? last_b : bank, addr[13:0]});
    end

endmodule

// File: rtl/sf_cntl.sv
// sf_cntl: StrataFlash pin sequencer with per-operation latency and a req/rdy handshake
module sf_cntl
    import cpumc_banked_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  req_type_t   req_type,
    input  logic [23:0] addr,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic        rdy,
    inout  wire  [7:0]  sf_d,
    output logic [23:0] sf_a,
    output logic        sf_byte,
    output logic        sf_ce0,
    output logic        sf_oe,
    output logic        sf_we
);

    localparam logic [4:0] LAT_RD = 5'd4;
    localparam logic [4:0] LAT_WR = 5'd8;
    localparam logic [4:0] LAT_ER = 5'd20;

    logic        busy_q, busy_d;
    logic [4:0]  cnt_q, cnt_d;
    req_type_t   type_q, type_d;
    logic [23:0] addr_q, addr_d;
    logic [7:0]  din_q, din_d;
    logic [7:0]  dout_q, dout_d;

    // accept a request when idle, count down the op, capture read data on the last cycle
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        type_d = type_q;
        addr_d = addr_q;
        din_d  = din_q;
        dout_d = dout_q;
        if (!busy_q) begin
            if (req) begin
                busy_d = 1'b1;
                type_d = req_type;
                addr_d = addr;
                din_d  = din;
                cnt_d  = req_type == RT_RD ? LAT_RD : req_type == RT_WR ? LAT_WR : LAT_ER;
            end
        end else if (cnt_q == 5'd0) begin
            busy_d = 1'b0;
            dout_d = type_q == RT_RD ? sf_d : dout_q;
        end else begin
            cnt_d = cnt_q - 5'd1;
        end
    end

    // operation registers, abandoned on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            type_q <= RT_RD;
            addr_q <= '0;
            din_q  <= '0;
            dout_q <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            type_q <= type_d;
            addr_q <= addr_d;
            din_q  <= din_d;
            dout_q <= dout_d;
        end
    end

    assign rdy     = !busy_q;
    assign dout    = dout_q;
    assign sf_a    = addr_q;
    assign sf_byte = 1'b0;
    assign sf_ce0  = !busy_q;
    assign sf_oe   = !(busy_q && type_q == RT_RD);
    assign sf_we   = !(busy_q && type_q != RT_RD && cnt_q != 5'd0);
    // erase drives the block-erase command byte, program drives the data byte
    assign sf_d    = (busy_q && type_q != RT_RD) ? (type_q == RT_ER ? 8'h20 : din_q) : 8'hzz;

endmodule

// File: rtl/single_port_ram_sync.sv
// single_port_ram_sync: single-port RAM with registered read (read-before-write)
module single_port_ram_sync #(
    parameter int AW = 11,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] mem [2**AW];

    // write port plus registered read of the old contents
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= din;
        dout <= mem[addr];
    end

endmodule

// File: rtl/cpumc_banked.sv
// cpumc_banked: banked CPU memory controller decoding work RAM, SRAM and flash-backed PRG
module cpumc_banked
    import cpumc_banked_pkg::*;
#(
    parameter int RAM_AW  = 11,
    parameter int SRAM_AW = 13,
    parameter int BANK_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        cfg,
    input  logic              req,
    input  logic              wr,
    input  logic              erase,
    input  logic [15:0]       addr,
    input  logic [7:0]        din,
    output logic [7:0]        dout,
    output logic              rdy,
    output logic              rd_valid,
    output logic [BANK_W-1:0] bank,
    inout  wire  [7:0]        sf_d,
    output logic [23:0]       sf_a,
    output logic              sf_byte,
    output logic              sf_ce0,
    output logic              sf_oe,
    output logic              sf_we
);

    state_t            state_q, state_d;
    logic [15:0]       addr_q, addr_d;
    logic [7:0]        din_q, din_d;
    mode_t             mode_q, mode_d;
    logic [3:0]        last_q, last_d;
    logic              wr_q, wr_d;
    logic              er_q, er_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic [7:0]        dout_q, dout_d;
    logic              rd_valid_q, rd_valid_d;
    logic              fl_rdy_q;

    mode_t       mode;
    region_t     rg, rg_q;
    logic        ram_we, sram_we, fl_req, sf_rdy, cfg_unused;
    logic [7:0]  ram_q, sram_q, sf_dout;
    logic [23:0] fl_addr;
    req_type_t   fl_type;

    assign mode       = mode_t'(cfg[1:0]);
    assign rg         = region_of(addr);
    assign rg_q       = region_of(addr_q);
    assign cfg_unused = ^cfg[3:2];
    assign fl_type    = er_q ? RT_ER : wr_q ? RT_WR : RT_RD;

    // request decode, bank register update and transaction sequencing
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        din_d      = din_q;
        mode_d     = mode_q;
        last_d     = last_q;
        wr_d       = wr_q;
        er_d       = er_q;
        bank_d     = bank_q;
        dout_d     = dout_q;
        rd_valid_d = 1'b0;
        ram_we     = 1'b0;
        sram_we    = 1'b0;
        fl_req     = 1'b0;
        case (state_q)
            ST_IDLE: if (req) begin
                addr_d = addr;
                din_d  = din;
                mode_d = mode;
                last_d = cfg[7:4];
                wr_d   = wr;
                er_d   = erase;
                if (erase) begin
                    state_d = (mode == MODE_PROG && rg == RG_PRG) ? ST_FL_ISSUE : ST_IDLE;
                end else if (wr) begin
                    ram_we  = rg == RG_RAM;
                    sram_we = rg == RG_SRAM;
                    if ((mode == MODE_UXROM && rg == RG_PRG) || (mode == MODE_PROG && rg == RG_BPORT))
                        bank_d = din[BANK_W-1:0];
                    state_d = (mode == MODE_PROG && rg == RG_PRG) ? ST_FL_ISSUE : ST_IDLE;
                end else begin
                    state_d = rg == RG_PRG ? ST_FL_ISSUE : ST_MEM_RD;
                end
            end
            ST_MEM_RD: begin
                dout_d     = rg_q == RG_RAM ? ram_q : rg_q == RG_SRAM ? sram_q : 8'h00;
                rd_valid_d = 1'b1;
                state_d    = ST_IDLE;
            end
            ST_FL_ISSUE: begin
                fl_req  = sf_rdy;
                state_d = sf_rdy ? ST_FL_WAIT : ST_FL_ISSUE;
            end
            ST_FL_WAIT: if (sf_rdy && !fl_rdy_q) begin
                rd_valid_d = !wr_q && !er_q;
                dout_d     = rd_valid_d ? sf_dout : dout_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // controller state, cleared by the active-low synchronous reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            din_q      <= '0;
            mode_q     <= MODE_NROM128;
            last_q     <= '0;
            wr_q       <= 1'b0;
            er_q       <= 1'b0;
            bank_q     <= '0;
            dout_q     <= '0;
            rd_valid_q <= 1'b0;
            fl_rdy_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            mode_q     <= mode_d;
            last_q     <= last_d;
            wr_q       <= wr_d;
            er_q       <= er_d;
            bank_q     <= bank_d;
            dout_q     <= dout_d;
            rd_valid_q <= rd_valid_d;
            fl_rdy_q   <= sf_rdy;
        end
    end

    assign dout     = dout_q;
    assign rdy      = state_q == ST_IDLE;
    assign rd_valid = rd_valid_q;
    assign bank     = bank_q;

    // RAM sees the live CPU address so read data is ready in MEM_RD
    single_port_ram_sync #(.AW(RAM_AW), .DW(8)) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (addr[RAM_AW-1:0]),
        .din  (din),
        .dout (ram_q)
    );

    generate
        if (SRAM_AW > 0) begin : g_sram
            single_port_ram_sync #(.AW(SRAM_AW), .DW(8)) u_sram (
                .clk  (clk),
                .we   (sram_we),
                .addr (addr[SRAM_AW-1:0]),
                .din  (din),
                .dout (sram_q)
            );
        end else begin : g_no_sram
            assign sram_q = 8'h00;
        end
    endgenerate

    cpumc_prg_map #(.BANK_W(BANK_W)) u_map (
        .mode (mode_q),
        .bank (bank_q),
        .last (last_q),
        .addr (addr_q[14:0]),
        .fa   (fl_addr)
    );

    sf_cntl u_sf (
        .clk      (clk),
        .rst      (~rst),
        .req      (fl_req),
        .req_type (fl_type),
        .addr     (fl_addr),
        .din      (din_q),
        .dout     (sf_dout),
        .rdy      (sf_rdy),
        .sf_d     (sf_d),
        .sf_a     (sf_a),
        .sf_byte  (sf_byte),
        .sf_ce0   (sf_ce0),
        .sf_oe    (sf_oe),
        .sf_we    (sf_we)
    );

endmodule

// File: tb/tb_cpumc_banked.sv
// tb_cpumc_banked: randomized and directed checks of cpumc_banked against a behavioural model
module tb_cpumc_banked;

    localparam int RAM_AW  = 11;
    localparam int SRAM_AW = 13;
    localparam int BANK_W  = 4;

    logic              clk = 1'b0, rst = 1'b0, req = 1'b0, wr = 1'b0, erase = 1'b0;
    logic [7:0]        cfg = 8'h00, din = 8'h00;
    logic [15:0]       addr = 16'h0000;
    logic [7:0]        dout;
    logic              rdy, rd_valid;
    logic [BANK_W-1:0] bank;
    wire  [7:0]        sf_d;
    logic [23:0]       sf_a;
    logic              sf_byte, sf_ce0, sf_oe, sf_we;

    int checks = 0, passes = 0;

    always #10 clk = ~clk;

    cpumc_banked #(.RAM_AW(RAM_AW), .SRAM_AW(SRAM_AW), .BANK_W(BANK_W)) dut (
        .clk(clk), .rst(rst), .cfg(cfg), .req(req), .wr(wr), .erase(erase), .addr(addr), .din(din),
        .dout(dout), .rdy(rdy), .rd_valid(rd_valid), .bank(bank), .sf_d(sf_d), .sf_a(sf_a),
        .sf_byte(sf_byte), .sf_ce0(sf_ce0), .sf_oe(sf_oe), .sf_we(sf_we)
    );

    function automatic logic [7:0] fbyte(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endfunction

    assign sf_d = (!sf_oe && sf_we) ? fbyte(sf_a) : 8'hzz;

    logic [7:0]  m_ram  [1 << RAM_AW];
    logic [7:0]  m_sram [1 << SRAM_AW];
    int          m_bank = 0;
    logic        e_valid, e_fl, e_we;
    logic [7:0]  e_dout, e_wd;
    logic [23:0] e_fa;
    logic        o_valid, o_ce, o_we, o_ovl;
    int          o_lat, o_busy;
    logic [7:0]  o_dout, o_wd;
    logic [23:0] o_fa;

    function automatic logic [23:0] exp_fa(input int mode, input int b, input int last, input int a);
        int off = a % 16384;
        case (mode)
            0:       return 24'(off);
            1:       return 24'(a % 32768);
            2:       return 24'(((a >= 'hC000) ? last : b) * 16384 + off);
            default: return 24'(b * 16384 + off);
        endcase
    endfunction

    task automatic model_apply(input logic [7:0] c, input logic w, input logic e, input logic [15:0] a, input logic [7:0] d);
        int mode = int'(c[1:0]);
        int last = int'(c[7:4]) % (1 << BANK_W);
        int ai   = int'(a);
        e_valid = 0; e_fl = 0; e_we = 0; e_dout = 0; e_wd = 0; e_fa = 0;
        if (e) begin
            if (mode == 3 && ai >= 'h8000) begin
                e_fl = 1; e_we = 1; e_wd = 8'h20; e_fa = exp_fa(mode, m_bank, last, ai);
            end
        end else if (w) begin
            if (ai < 'h2000) m_ram[ai % (1 << RAM_AW)] = d;
            else if (ai >= 'h6000 && ai < 'h8000) m_sram[ai % (1 << SRAM_AW)] = d;
            else if (ai >= 'h8000 && mode == 2) m_bank = int'(d) % (1 << BANK_W);
            else if (ai >= 'h8000 && mode == 3) begin
                e_fl = 1; e_we = 1; e_wd = d; e_fa = exp_fa(mode, m_bank, last, ai);
            end else if (ai >= 'h4020 && ai < 'h6000 && mode == 3) m_bank = int'(d) % (1 << BANK_W);
        end else begin
            e_valid = 1;
            if (ai < 'h2000) e_dout = m_ram[ai % (1 << RAM_AW)];
            else if (ai >= 'h6000 && ai < 'h8000) e_dout = m_sram[ai % (1 << SRAM_AW)];
            else if (ai >= 'h8000) begin
                e_fl = 1; e_fa = exp_fa(mode, m_bank, last, ai); e_dout = fbyte(e_fa);
            end
        end
    endtask

    // one transaction, observing pins until the controller is idle; inj>0 pulses a req in that busy cycle
    task automatic xact(input logic [7:0] c, input logic w, input logic e, input logic [15:0] a, input logic [7:0] d, input int inj);
        int cyc;
        model_apply(c, w, e, a, d);
        cfg = c; wr = w; erase = e; addr = a; din = d; req = 1'b1;
        o_valid = 0; o_lat = 0; o_dout = 0; o_ce = 0; o_fa = 0; o_we = 0; o_wd = 0; o_busy = 0; o_ovl = 0;
        @(posedge clk); #1;
        req = 1'b0; wr = 1'b0; erase = 1'b0;
        for (cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            if (rd_valid) begin o_valid = 1; o_lat = cyc; o_dout = dout; end
            if (!sf_ce0) begin o_ce = 1; o_fa = sf_a; if (rdy) o_ovl = 1; end
            if (!sf_we) begin o_we = 1; o_wd = sf_d; end
            if (rdy) break;
            o_busy++;
            if (cyc == inj) begin req = 1'b1; wr = 1'b1; addr = 16'h0050; din = 8'h77; end
            else begin req = 1'b0; wr = 1'b0; end
            @(posedge clk); #1;
        end
        req = 1'b0; wr = 1'b0;
        if (cyc > 200) begin
            checks++;
            $display("FAIL xact_timeout addr=%h: rdy still 0 after 200 cycles, want 1", a);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (rdy !== 1'b1) $display("FAIL reset_rdy got %b want 1", rdy); else passes++;
        checks++; if (bank !== '0) $display("FAIL reset_bank got %h want 0", bank); else passes++;
        checks++; if (dout !== 8'h00) $display("FAIL reset_dout got %h want 00", dout); else passes++;
        checks++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid got %b want 0", rd_valid); else passes++;
        rst = 1'b1;
    endtask

    task automatic test_ram_mirror();
        xact(8'h00, 1, 0, 16'h0123, 8'hA5, 0);
        checks++; if (o_busy !== 0) $display("FAIL ram_wr_rdy busy=%0d want 0", o_busy); else passes++;
        xact(8'h00, 0, 0, 16'h1923, 8'h00, 0);
        checks++; if (o_valid !== 1'b1) $display("FAIL mirror_valid got %b want 1", o_valid); else passes++;
        checks++; if (o_lat !== 2) $display("FAIL mirror_latency got %0d want 2", o_lat); else passes++;
        checks++; if (o_dout !== 8'hA5) $display("FAIL mirror_dout got %h want a5", o_dout); else passes++;
        xact(8'h00, 1, 0, 16'h6ABC, 8'h3C, 0);
        xact(8'h00, 0, 0, 16'h6ABC, 8'h00, 0);
        checks++; if (o_dout !== 8'h3C) $display("FAIL sram_dout got %h want 3c", o_dout); else passes++;
        xact(8'h00, 0, 0, 16'h3000, 8'h00, 0);
        checks++; if (o_valid !== 1'b1 || o_dout !== 8'h00) $display("FAIL unmapped_rd valid=%b dout=%h want 1/00", o_valid, o_dout); else passes++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [8];
        for (int i = 0; i < 8; i++) begin
            vals[i] = 8'($urandom);
            xact(8'h00, 1, 0, 16'h0200 + 16'(i), vals[i], 0);
            checks++; if (o_busy !== 0) $display("FAIL b2b_wr_rdy i=%0d busy=%0d want 0", i, o_busy); else passes++;
        end
        for (int i = 0; i < 8; i++) begin
            xact(8'h00, 0, 0, 16'h0A00 + 16'(i), 8'h00, 0);
            checks++; if (o_dout !== vals[i]) $display("FAIL b2b_rd i=%0d got %h want %h", i, o_dout, vals[i]); else passes++;
        end
    endtask

    task automatic test_uxrom();
        xact(8'h72, 1, 0, 16'h8000, 8'h03, 0);
        checks++; if (bank !== 4'h3) $display("FAIL ux_bank got %h want 3", bank); else passes++;
        checks++; if (o_we !== 1'b0 || o_ce !== 1'b0 || o_busy !== 0) $display("FAIL ux_no_flash we=%b ce=%b busy=%0d want 0/0/0", o_we, o_ce, o_busy); else passes++;
        xact(8'h72, 0, 0, 16'h8010, 8'h00, 0);
        checks++; if (o_fa !== 24'h00C010) $display("FAIL ux_fa_lo got %h want 00c010", o_fa); else passes++;
        checks++; if (o_dout !== fbyte(24'h00C010)) $display("FAIL ux_dout_lo got %h want %h", o_dout, fbyte(24'h00C010)); else passes++;
        xact(8'h72, 0, 0, 16'hC010, 8'h00, 0);
        checks++; if (o_fa !== 24'h01C010) $display("FAIL ux_fa_hi got %h want 01c010", o_fa); else passes++;
        xact(8'h72, 1, 0, 16'hFFFF, 8'hF6, 0);
        checks++; if (bank !== 4'h6) $display("FAIL ux_bank_trunc got %h want 6", bank); else passes++;
    endtask

    task automatic test_nrom();
        xact(8'h00, 0, 0, 16'hC005, 8'h00, 0);
        checks++; if (o_fa !== 24'h000005) $display("FAIL nrom128_fa got %h want 000005", o_fa); else passes++;
        checks++; if (o_valid !== 1'b1 || o_dout !== fbyte(24'h000005)) $display("FAIL nrom128_dout got %h want %h", o_dout, fbyte(24'h000005)); else passes++;
        xact(8'h01, 0, 0, 16'hC005, 8'h00, 0);
        checks++; if (o_fa !== 24'h004005) $display("FAIL nrom256_fa got %h want 004005", o_fa); else passes++;
    endtask

    task automatic test_program();
        xact(8'h03, 1, 0, 16'h0050, 8'h11, 0);
        xact(8'h03, 1, 0, 16'h5000, 8'h05, 0);
        checks++; if (bank !== 4'h5) $display("FAIL prog_bank got %h want 5", bank); else passes++;
        xact(8'h03, 1, 0, 16'h8001, 8'h3C, 3);
        checks++; if (o_we !== 1'b1 || o_wd !== 8'h3C) $display("FAIL prog_write we=%b data=%h want 1/3c", o_we, o_wd); else passes++;
        checks++; if (o_fa !== 24'h014001) $display("FAIL prog_fa got %h want 014001", o_fa); else passes++;
        checks++; if (o_ovl !== 1'b0 || o_busy < 9) $display("FAIL prog_rdy_held ovl=%b busy=%0d want 0/>=9", o_ovl, o_busy); else passes++;
        checks++; if (o_valid !== 1'b0) $display("FAIL prog_no_rd_valid got %b want 0", o_valid); else passes++;
        xact(8'h00, 0, 0, 16'h0050, 8'h00, 0);
        checks++; if (o_dout !== 8'h11) $display("FAIL busy_req_dropped got %h want 11", o_dout); else passes++;
    endtask

    task automatic test_erase();
        xact(8'h03, 1, 1, 16'h8000, 8'h99, 0);
        checks++; if (o_we !== 1'b1 || o_wd !== 8'h20) $display("FAIL erase_cmd we=%b data=%h want 1/20", o_we, o_wd); else passes++;
        checks++; if (o_fa !== 24'h014000) $display("FAIL erase_fa got %h want 014000", o_fa); else passes++;
        xact(8'h01, 1, 1, 16'h8000, 8'h99, 0);
        checks++; if (o_ce !== 1'b0 || o_busy !== 0) $display("FAIL erase_ignored ce=%b busy=%0d want 0/0", o_ce, o_busy); else passes++;
        checks++; if (bank !== 4'h5) $display("FAIL erase_bank got %h want 5", bank); else passes++;
    endtask

    task automatic test_random();
        logic [7:0]  c, d;
        logic [15:0] a;
        logic        w, e;
        for (int i = 0; i < 16; i++) begin
            xact(8'h00, 1, 0, 16'h0100 + 16'(i), 8'($urandom), 0);
            xact(8'h00, 1, 0, 16'h6000 + 16'(i * 'h1F3), 8'($urandom), 0);
        end
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 5))
                0:       a = 16'($urandom_range(0, 3) * 'h800 + 'h100 + $urandom_range(0, 15));
                1:       a = 16'('h6000 + $urandom_range(0, 15) * 'h1F3);
                4:       a = 16'($urandom_range('h2000, 'h5FFF));
                5:       a = 16'($urandom_range('h4020, 'h5FFF));
                default: a = 16'($urandom_range('h8000, 'hFFFF));
            endcase
            c = 8'($urandom);
            d = 8'($urandom);
            w = 1'($urandom_range(0, 1));
            e = $urandom_range(0, 7) == 0;
            xact(c, w, e, a, d, 0);
            checks++; if (o_valid !== e_valid) $display("FAIL rnd_valid n=%0d a=%h got %b want %b", n, a, o_valid, e_valid); else passes++;
            if (e_valid) begin
                checks++; if (o_dout !== e_dout) $display("FAIL rnd_dout n=%0d a=%h got %h want %h", n, a, o_dout, e_dout); else passes++;
            end
            checks++; if (o_ce !== e_fl) $display("FAIL rnd_flash_op n=%0d a=%h got %b want %b", n, a, o_ce, e_fl); else passes++;
            if (e_fl) begin
                checks++; if (o_fa !== e_fa) $display("FAIL rnd_fa n=%0d a=%h got %h want %h", n, a, o_fa, e_fa); else passes++;
            end
            checks++; if (o_we !== e_we) $display("FAIL rnd_we n=%0d a=%h got %b want %b", n, a, o_we, e_we); else passes++;
            if (e_we) begin
                checks++; if (o_wd !== e_wd) $display("FAIL rnd_wdata n=%0d got %h want %h", n, o_wd, e_wd); else passes++;
            end
            checks++; if (bank !== BANK_W'(m_bank) || o_ovl !== 1'b0) $display("FAIL rnd_bank n=%0d got %h/%b want %h/0", n, bank, o_ovl, BANK_W'(m_bank)); else passes++;
        end
    endtask

    task automatic test_reset_abort();
        int seen = 0;
        xact(8'h00, 1, 0, 16'h0300, 8'hE7, 0);
        xact(8'h00, 0, 0, 16'h0300, 8'h00, 0);
        xact(8'h03, 1, 0, 16'h4020, 8'h09, 0);
        cfg = 8'h03; addr = 16'h9000; wr = 1'b0; erase = 1'b0; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (rdy !== 1'b0 || sf_ce0 !== 1'b0) $display("FAIL abort_inflight rdy=%b ce0=%b want 0/0", rdy, sf_ce0); else passes++;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        m_bank = 0;
        @(negedge clk);
        checks++; if (rdy !== 1'b1 || bank !== '0) $display("FAIL abort_state rdy=%b bank=%h want 1/0", rdy, bank); else passes++;
        checks++; if (dout !== 8'h00 || sf_ce0 !== 1'b1) $display("FAIL abort_dout dout=%h ce0=%b want 00/1", dout, sf_ce0); else passes++;
        for (int i = 0; i < 40; i++) begin
            if (rd_valid) seen++;
            @(negedge clk);
        end
        checks++; if (seen !== 0) $display("FAIL abort_no_rd_valid pulses=%0d want 0", seen); else passes++;
    endtask

    initial begin
        test_reset();
        test_ram_mirror();
        test_back_to_back();
        test_uxrom();
        test_nrom();
        test_program();
        test_erase();
        test_random();
        test_reset_abort();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/cpumc_banked.md
Name: cpumc_banked

Overview:
- Next-generation CPU memory controller for the cart.
- Decodes the 16-bit CPU address into:
  - internal work RAM, mirrored;
  - optional battery-style SRAM at 0x6000;
  - PRG-ROM held in StrataFlash through sf_cntl.
- Adds four mapper modes (NROM-128, NROM-256, UxROM bank switching, flash program mode), a registered request/valid handshake with variable flash latency, and a bank register.
- Sits between the CPU bus interface and the flash pins.

Parameters:
- RAM_AW, 11: work RAM address width (2^11 bytes, mirrored over 0x0000-0x1FFF).
- SRAM_AW, 13: SRAM address width at 0x6000-0x7FFF; 0 removes the SRAM (region reads 0x00).
- BANK_W, 4: PRG bank register width (16 KB banks).

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  reset. Synchronous and active-low, sampled on the rising edge of clk.
- cfg  in  8  cfg[1:0] mode (0 NROM-128, 1 NROM-256, 2 UxROM, 3 PROGRAM); cfg[7:4] last-bank index for UxROM.
- req  in  1  one-cycle request strobe; accepted only while rdy=1.
- wr  in  1  request is a write.
- erase  in  1  request is a flash erase; PROGRAM mode only.
- addr  in  16  CPU address.
- din  in  8  write data.
- dout  out  8  read data; registered, held until the next read completes.
- rdy  out  1  controller idle and able to accept req.
- rd_valid  out  1  one-cycle pulse when dout is updated.
- bank  out  BANK_W  current bank register (debug/visibility).
- sf_d  inout  8, sf_a  out  24, sf_byte/sf_ce0/sf_oe/sf_we  out  1: flash pins, passed through sf_cntl.

Behaviour:
- Reset (rst=0 at clk edge):
  - state=IDLE, bank=0, dout=0x00, rd_valid=0, rdy=1 on the following cycle.
  - sf_cntl reset is driven from ~rst, so a flash op in flight is abandoned.
  - No rd_valid is generated for an aborted request.
- Request acceptance:
  - On req&&rdy, latch addr, din, wr, erase and cfg; the latched cfg governs the whole transaction.
  - req while rdy=0 is ignored (dropped, no error).
  - cfg changes are only legal while idle.
- Regions, decoded from the latched addr:
  - 0x0000-0x1FFF: RAM, index addr[RAM_AW-1:0].
  - 0x2000-0x401F: unmapped.
  - 0x4020-0x5FFF: bank-register port in PROGRAM mode only; otherwise unmapped.
  - 0x6000-0x7FFF: SRAM, index addr[SRAM_AW-1:0].
  - 0x8000-0xFFFF: PRG.
- FSM states: IDLE, MEM_RD, FL_ISSUE, FL_WAIT.
  - IDLE: on an accepted request, go to MEM_RD for a RAM/SRAM/unmapped read; go to FL_ISSUE for a flash read, a PROGRAM write or a PROGRAM erase.
  - IDLE, RAM/SRAM write: the write strobe is asserted in the acceptance cycle and the FSM stays IDLE; rdy stays 1, so back-to-back writes are allowed every cycle.
  - IDLE, writes that complete in one cycle and stay IDLE: bank-register writes, UxROM PRG writes, and PRG writes or erases in modes 0/1/2 (the latter are discarded; no flash activity).
  - MEM_RD: synchronous RAM data is ready. Load dout (0x00 for unmapped), pulse rd_valid, return to IDLE. Read latency is 2 cycles from req to rd_valid.
  - FL_ISSUE: wait for sf_cntl rdy=1, drive its req for 1 cycle, then go to FL_WAIT.
    - req_type = 2 for erase, 1 for write, 0 for read.
  - FL_WAIT: wait for sf_cntl rdy rising. For a read, load dout and pulse rd_valid. Return to IDLE.
- rdy=1 only in IDLE.
- Flash address, zero-extended to 24 bits (b = bank, L = cfg[7:4] resized to BANK_W):
  - mode 0: {0, addr[13:0]} (0x8000 and 0xC000 windows mirror).
  - mode 1: {0, addr[14:0]}.
  - mode 2: addr[14]=0 gives {b, addr[13:0]}; addr[14]=1 gives {L, addr[13:0]}.
  - mode 3: {b, addr[13:0]}.
- Bank register updates:
  - UxROM write to 0x8000-0xFFFF: bank <= din[BANK_W-1:0].
  - PROGRAM write to 0x4020-0x5FFF: bank <= din[BANK_W-1:0].
  - Upper din bits are ignored. The update is visible to the next request.
- Simultaneous wr and erase: erase wins.
- Erase outside PROGRAM mode or outside PRG range: ignored, no state change.

Decomposition:
- Shared include cpumc_defs.vh holds:
  - mode codes (MODE_NROM128=0, MODE_NROM256=1, MODE_UXROM=2, MODE_PROG=3);
  - sf_cntl req_type codes (RD=0, WR=1, ER=2);
  - region base constants.
- Reuses existing single_port_ram_sync (RAM, SRAM) and sf_cntl instances.
- One natural sub-module: cpumc_prg_map, a combinational mode/bank to flash-address mapper, so it can be unit-tested separately.

Test Plan:
- Write 0xA5 to 0x0123, read 0x1923 -> rd_valid 2 cycles after req, dout=0xA5 (mirror).
- Mode 2, cfg[7:4]=7, write 0x03 to 0x8000, read 0x8010 then 0xC010 -> sf_a=0x00C010 then 0x01C010; bank=3; no sf_we activity.
- Mode 0, read 0xC005 -> sf_a=0x000005; mode 1, read 0xC005 -> sf_a=0x004005.
- Mode 3, write 0x05 to 0x5000, then write 0x3C to 0x8001 -> sf_cntl req_type=1, sf_a=0x014001; rdy held 0 until flash done; a second req during busy is dropped.
- Mode 3, erase to 0x8000 with wr=1 -> req_type=2. Mode 1, same stimulus -> no sf_cntl req, rdy stays 1.
- Flash read in FL_WAIT, rst=0 for one cycle -> next cycle rdy=1, bank=0, dout=0x00, and no rd_valid ever for that read.
